uart_serializer_param: RTL

//   Parametrised successor to the fixed 8-bit UART serializer. It captures a parallel word

---
 rtl/uart_serializer_param.sv | 104 ++++++++++
 1 files changed

// File: rtl/uart_serializer_param.sv
// Parametrised UART bit serializer: captures a parallel word on a valid/ready
// handshake and shifts it out one bit per ser_en strobe, LSB- or MSB-first,
// with optional parity and a one-bit idle-high gap before the next frame.
module uart_serializer_param #(
  parameter int DATA_WIDTH = 8,
  parameter int MSB_FIRST  = 0,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p_valid,
  output logic                  p_ready,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  ser_en,
  output logic                  ser_data,
  output logic                  ser_busy,
  output logic                  ser_done
);

  localparam int            CW   = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_DRAIN} state_t;

  state_t                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CW-1:0]         r_cnt;
  logic                  r_par;
  logic                  r_ser;
  logic                  r_done;
  logic                  w_bit;
  logic                  w_last;

  // Next bit always sits at the end of the shift register facing the line.
  assign w_bit  = (MSB_FIRST != 0) ? r_shift[DATA_WIDTH-1] : r_shift[0];
  // Counter equals DATA_WIDTH-1 on the strobe that emits the final data bit.
  assign w_last = (r_cnt == LAST);

  assign p_ready  = (r_state == S_IDLE);
  assign ser_busy = (r_state != S_IDLE);
  assign ser_data = r_ser;
  assign ser_done = r_done;

  // State register; async reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; ser_en is deliberately not looked at in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (p_valid) w_next = S_SHIFT;
      S_SHIFT:  if (ser_en && w_last) w_next = (PARITY_EN != 0) ? S_PARITY : S_DRAIN;
      S_PARITY: if (ser_en) w_next = S_DRAIN;
      S_DRAIN:  if (ser_en) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath: capture on load, emit one bit per strobe, pulse done with the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_par   <= 1'b0;
      r_ser   <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (p_valid) begin
            r_shift <= p_data;
            r_cnt   <= '0;
            r_par   <= (^p_data) ^ (PARITY_ODD != 0);
          end
        end
        S_SHIFT: begin
          if (ser_en) begin
            r_ser   <= w_bit;
            r_cnt   <= r_cnt + CW'(1);
            r_shift <= (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);
            r_done  <= w_last && (PARITY_EN == 0);
          end
        end
        S_PARITY: begin
          if (ser_en) begin
            r_ser  <= r_par;
            r_done <= 1'b1;
          end
        end
        S_DRAIN: begin
          // Last bit has held for its full bit time; return the line high.
          if (ser_en) r_ser <= 1'b1;
        end
        default: r_ser <= 1'b1;
      endcase
    end
  end

endmodule
